// File: rtl/rtc_timebase.sv
// Real-time-clock time base: programmable prescaler -> sub-second counter ->
// 24-hour sec/min/hr cascade, with synchronous time load and one-shot alarm.
module rtc_timebase #(
    parameter int DIV_W = 24,
    parameter int TPS   = 100,
    parameter int TPS_W = 7
) (
    input  logic             i_sclk,
    input  logic             i_reset_n,
    input  logic             i_timerenb,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_load,
    input  logic [5:0]       i_load_sec,
    input  logic [5:0]       i_load_min,
    input  logic [4:0]       i_load_hr,
    input  logic             i_alarm_en,
    input  logic [5:0]       i_alarm_sec,
    input  logic [5:0]       i_alarm_min,
    input  logic [4:0]       i_alarm_hr,
    output logic             o_basetick,
    output logic             o_sec_tick,
    output logic [5:0]       o_sec,
    output logic [5:0]       o_min,
    output logic [4:0]       o_hr,
    output logic             o_alarm
);

    localparam logic [TPS_W-1:0] SUB_LAST = TPS_W'(TPS - 1);

    logic [DIV_W-1:0] pre_cnt;
    logic [TPS_W-1:0] sub_cnt;
    logic             base_hit;
    logic             sec_hit;
    logic             alarm_hit;

    // >= rather than == so a divisor lowered below the running count wraps at once.
    assign base_hit  = i_timerenb && (pre_cnt >= i_div);
    assign sec_hit   = base_hit && (sub_cnt >= SUB_LAST);
    // o_sec_tick high means o_hr/o_min/o_sec already hold the new time.
    assign alarm_hit = i_timerenb && i_alarm_en && o_sec_tick &&
                       (o_hr == i_alarm_hr) && (o_min == i_alarm_min) &&
                       (o_sec == i_alarm_sec);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_cnt    <= '0;
            sub_cnt    <= '0;
            o_basetick <= 1'b0;
            o_sec_tick <= 1'b0;
            o_alarm    <= 1'b0;
        end else if (i_load) begin
            pre_cnt    <= '0;
            sub_cnt    <= '0;
            o_basetick <= 1'b0;
            o_sec_tick <= 1'b0;
            o_alarm    <= 1'b0;
        end else begin
            o_basetick <= base_hit;
            o_sec_tick <= sec_hit;
            o_alarm    <= alarm_hit;
            if (i_timerenb) begin
                pre_cnt <= base_hit ? '0 : pre_cnt + DIV_W'(1);
            end
            if (base_hit) begin
                sub_cnt <= sec_hit ? '0 : sub_cnt + TPS_W'(1);
            end
        end
    end

    // Out-of-range loaded values survive until their next increment, where >= wraps them.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sec <= '0;
            o_min <= '0;
            o_hr  <= '0;
        end else if (i_load) begin
            o_sec <= i_load_sec;
            o_min <= i_load_min;
            o_hr  <= i_load_hr;
        end else if (sec_hit) begin
            if (o_sec >= 6'd59) begin
                o_sec <= '0;
                if (o_min >= 6'd59) begin
                    o_min <= '0;
                    o_hr  <= (o_hr >= 5'd23) ? 5'd0 : o_hr + 5'd1;
                end else begin
                    o_min <= o_min + 6'd1;
                end
            end else begin
                o_sec <= o_sec + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timebase.sv
// Self-checking bench for rtc_timebase: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a behavioural model.
module tb_rtc_timebase;

    localparam int TPS = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] div = '0;
    logic        ld = 1'b0;
    logic [5:0]  ld_sec = '0, ld_min = '0;
    logic [4:0]  ld_hr = '0;
    logic        al_en = 1'b0;
    logic [5:0]  al_sec = '0, al_min = '0;
    logic [4:0]  al_hr = '0;
    logic        basetick, sec_tick, alarm;
    logic [5:0]  sec, min;
    logic [4:0]  hr;

    int n_err = 0;
    int n_chk = 0;

    rtc_timebase #(.DIV_W(24), .TPS(TPS), .TPS_W(7)) dut (
        .i_sclk(clk), .i_reset_n(rst_n), .i_timerenb(en), .i_div(div),
        .i_load(ld), .i_load_sec(ld_sec), .i_load_min(ld_min), .i_load_hr(ld_hr),
        .i_alarm_en(al_en), .i_alarm_sec(al_sec), .i_alarm_min(al_min), .i_alarm_hr(al_hr),
        .o_basetick(basetick), .o_sec_tick(sec_tick), .o_sec(sec), .o_min(min),
        .o_hr(hr), .o_alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Time-of-day advance by one second: each field wraps once it has reached its top value.
    function automatic logic [16:0] next_tod(input int h, input int m, input int s);
        int hh = h, mm = m, ss = s;
        if (s >= 59) begin
            ss = 0;
            if (m >= 59) begin
                mm = 0;
                hh = (h >= 23) ? 0 : h + 1;
            end else mm = m + 1;
        end else ss = s + 1;
        return {5'(hh), 6'(mm), 6'(ss)};
    endfunction

    // Behavioural model: ticks counted in plain integers, registered outputs as bits.
    int m_cnt, m_sub, m_s, m_m, m_h;
    bit m_bt, m_st, m_al;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_sub = 0; m_s = 0; m_m = 0; m_h = 0;
            m_bt = 0; m_st = 0; m_al = 0;
        end else begin
            m_al = !ld && en && al_en && m_st &&
                   (m_h == int'(al_hr)) && (m_m == int'(al_min)) && (m_s == int'(al_sec));
            if (ld) begin
                m_s = ld_sec; m_m = ld_min; m_h = ld_hr;
                m_cnt = 0; m_sub = 0; m_bt = 0; m_st = 0;
            end else if (en) begin
                m_bt = (m_cnt >= int'(div));
                m_st = 0;
                if (m_bt) begin
                    m_cnt = 0;
                    if (m_sub >= TPS - 1) begin
                        logic [16:0] t;
                        m_sub = 0;
                        m_st = 1;
                        t = next_tod(m_h, m_m, m_s);
                        m_h = t[16:12]; m_m = t[11:6]; m_s = t[5:0];
                    end else m_sub++;
                end else m_cnt++;
            end else begin
                m_bt = 0; m_st = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("basetick", 32'(basetick), 32'(m_bt));
        check("sec_tick", 32'(sec_tick), 32'(m_st));
        check("alarm", 32'(alarm), 32'(m_al));
        check("time", {15'd0, hr, min, sec}, {15'd0, 5'(m_h), 6'(m_m), 6'(m_s)});
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ld = 1'b1; ld_hr = h; ld_min = m; ld_sec = s;
        step();
        ld = 1'b0;
    endtask

    int pulses;

    initial begin
        // Reset state and base period with div = 4.
        en = 1'b1; div = 24'd4;
        step(3);
        check("reset_outputs", {14'd0, basetick, sec_tick, alarm, hr, min, sec}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            step();
            if (k == 4)   check("bt_edge4", 32'(basetick), 32'd0);
            if (k == 5)   check("bt_edge5", 32'(basetick), 32'd1);
            if (k == 10)  check("bt_edge10", 32'(basetick), 32'd1);
            if (k == 499) check("st_edge499", 32'(sec_tick), 32'd0);
        end
        check("st_edge500", 32'(sec_tick), 32'd1);
        check("sec_edge500", 32'(sec), 32'd1);

        // Full wrap from 23:59:59 with div = 0.
        div = 24'd0;
        load_time(5'd23, 6'd59, 6'd59);
        check("load_visible", {15'd0, hr, min, sec}, {15'd0, 5'd23, 6'd59, 6'd59});
        step(99);
        check("wrap_st_99", 32'(sec_tick), 32'd0);
        step();
        check("wrap_st_100", 32'(sec_tick), 32'd1);
        check("wrap_time", {15'd0, hr, min, sec}, 32'd0);

        // Alarm at 00:01:00 after loading 00:00:58.
        al_en = 1'b1; al_hr = 5'd0; al_min = 6'd1; al_sec = 6'd0;
        load_time(5'd0, 6'd0, 6'd58);
        pulses = 0;
        for (int k = 1; k <= 210; k++) begin
            step();
            pulses += int'(alarm);
            if (k == 200) begin
                check("alarm_st_200", 32'(sec_tick), 32'd1);
                check("alarm_time_200", {15'd0, hr, min, sec}, {15'd0, 5'd0, 6'd1, 6'd0});
                check("alarm_200", 32'(alarm), 32'd0);
            end
            if (k == 201) check("alarm_201", 32'(alarm), 32'd1);
        end
        check("alarm_count", 32'(pulses), 32'd1);
        load_time(5'd0, 6'd1, 6'd0);
        pulses = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            pulses += int'(alarm);
        end
        check("alarm_on_load", 32'(pulses), 32'd0);
        al_en = 1'b0;

        // Enable gap of 37 cycles delays the next base tick by 37.
        div = 24'd4;
        load_time(5'd1, 6'd2, 6'd3);
        step(2);
        en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 37; k++) begin
            step();
            pulses += int'(basetick);
        end
        en = 1'b1;
        step(2);
        check("gap_pulses", 32'(pulses + int'(basetick)), 32'd0);
        step();
        check("gap_tick_42", 32'(basetick), 32'd1);

        // Load colliding with a due tick.
        load_time(5'd2, 6'd3, 6'd4);
        step(4);
        load_time(5'd12, 6'd34, 6'd56);
        check("collide_no_tick", 32'(basetick), 32'd0);
        check("collide_time", {15'd0, hr, min, sec}, {15'd0, 5'd12, 6'd34, 6'd56});
        step(4);
        check("collide_4", 32'(basetick), 32'd0);
        step();
        check("collide_5", 32'(basetick), 32'd1);

        // Divisor drop from 20 to 3 with the count at 10.
        div = 24'd20;
        load_time(5'd12, 6'd34, 6'd56);
        step(10);
        div = 24'd3;
        step();
        check("divchg_wrap", 32'(basetick), 32'd1);
        step(3);
        check("divchg_3", 32'(basetick), 32'd0);
        step();
        check("divchg_4", 32'(basetick), 32'd1);

        // Asynchronous reset between clock edges.
        step(7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {14'd0, basetick, sec_tick, alarm, hr, min, sec}, 32'd0);
        step(2);
        rst_n = 1'b1;

        // Randomized run against the model.
        for (int k = 0; k < 15000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            div = ($urandom_range(0, 19) == 0) ? 24'($urandom_range(0, 9)) : 24'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) al_en = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 399) == 0);
            if (ld) begin
                logic [16:0] t;
                ld_sec = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(58, 59)) : 6'($urandom_range(0, 63));
                ld_min = ($urandom_range(0, 1) == 0) ? 6'd59 : 6'($urandom_range(0, 63));
                ld_hr  = ($urandom_range(0, 1) == 0) ? 5'd23 : 5'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) begin
                    t = next_tod(int'(ld_hr), int'(ld_min), int'(ld_sec));
                    al_hr = t[16:12]; al_min = t[11:6]; al_sec = t[5:0];
                end
            end
            step();
        end
        ld = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rtc_timebase.md
# rtc_timebase

Parametrised successor to the fixed real-time-clock base timer. It divides the system clock into a programmable base tick and cascades it into a 24-hour seconds/minutes/hours time-of-day. It adds synchronous time load and a single-shot alarm compare. It sits between the system clock domain and the RTC register/interrupt logic; all outputs are registered in the `i_sclk` domain.

## Interface

**Parameters**
- `DIV_W`, default 24: width of the runtime prescaler divisor.
- `TPS`, default 100: base ticks per second (100 gives a 10 ms base tick).
- `TPS_W`, default 7: width of the sub-second counter; must satisfy 2^TPS_W ≥ TPS.

**Ports**
- One clock; reset is asynchronous and active-low.
- `i_sclk` input 1: system clock, rising-edge.
- `i_reset_n` input 1: asynchronous active-low reset.
- `i_timerenb` input 1: count enable; low freezes all counters.
- `i_div` input DIV_W: prescaler divisor; base tick period is i_div+1 cycles.
- `i_load` input 1: one-cycle strobe that loads the time fields below.
- `i_load_sec` input 6: seconds value to load.
- `i_load_min` input 6: minutes value to load.
- `i_load_hr` input 5: hours value to load.
- `i_alarm_en` input 1: alarm compare enable.
- `i_alarm_sec` input 6: alarm seconds.
- `i_alarm_min` input 6: alarm minutes.
- `i_alarm_hr` input 5: alarm hours.
- `o_basetick` output 1: one-cycle pulse per base tick.
- `o_sec_tick` output 1: one-cycle pulse per completed second.
- `o_sec` output 6: current seconds.
- `o_min` output 6: current minutes.
- `o_hr` output 5: current hours.
- `o_alarm` output 1: one-cycle alarm pulse.

## Operation

**Reset.** While `i_reset_n` is low, the prescaler, sub-second counter, `o_sec`, `o_min`, `o_hr`, `o_basetick`, `o_sec_tick` and `o_alarm` are all 0. Asserting reset mid-count clears all state immediately.

**Prescaler.** When `i_timerenb` is high, the count increments each cycle. When count ≥ `i_div`, the count returns to 0 and the cycle is a base tick. The ≥ compare means that lowering `i_div` below the current count wraps on the next cycle and never runs away. `i_div` = 0 gives a base tick every enabled cycle.

**Sub-second counter.** Increments on each base tick. At a base tick with the counter ≥ TPS-1, it wraps to 0 and a second completes.

**Time cascade.** On a completed second:
- sec increments; when sec ≥ 59 it wraps to 0 and min increments.
- when min ≥ 59 it wraps to 0 and hr increments.
- when hr ≥ 23 it wraps to 0.

Out-of-range values from a load are held as loaded and wrap to 0 at their next increment.

**Enable.** With `i_timerenb` low, all counters hold their values and no tick or alarm pulses are generated. Load still operates.

**Load.** When `i_load` is high, sec/min/hr take the load values, and the prescaler and sub-second counter clear to 0. Load has priority over a coincident tick; that tick is discarded and no pulses are emitted in that cycle. Load works regardless of `i_timerenb`.

**Alarm.** `o_alarm` pulses only when a completed second moves the time to a value equal to (`i_alarm_hr`, `i_alarm_min`, `i_alarm_sec`) with `i_alarm_en` high. A load that lands on the alarm time does not fire. Deasserting `i_alarm_en` blocks any further pulses, including one already pending.

## Timing

- `o_basetick` is registered. After reset release with enable high and `i_div` = D, the first pulse is at rising edge D+1; pulses then repeat every D+1 cycles.
- `o_sec_tick` is asserted in the same cycle as the `o_basetick` that completes the second. `o_sec`, `o_min` and `o_hr` show the new values in that same cycle.
- `o_alarm` is asserted exactly one cycle after the `o_sec_tick` whose new time matches, and lasts one cycle.
- Load latency: fields are visible on `o_*` the cycle after the `i_load` edge. The first base tick after a load occurs D+1 enabled cycles later.
- A change to `i_div` takes effect at the next compare; no restart is needed.
- Dropping `i_timerenb` in the cycle a tick would occur suppresses that tick.

## Test plan

- **Reset and period.** Reset, then enable with `i_div` = 4 and TPS = 100 → `o_basetick` pulses at cycles 5, 10, 15, …; `o_sec_tick` first pulses at cycle 500 with `o_sec` = 1.
- **Full wrap.** Load 23:59:59 with `i_div` = 0 and TPS = 100 → after 100 cycles, `o_sec_tick` pulses and time reads 00:00:00.
- **Alarm.** Alarm at 00:01:00, enabled; load 00:00:58 → `o_alarm` pulses once, one cycle after the second `o_sec_tick`. A load of 00:01:00 produces no pulse.
- **Enable gating.** Deassert `i_timerenb` for 37 cycles mid-count → no pulses during the gap; the next `o_basetick` is delayed by exactly 37 cycles.
- **Load/tick collision and divider change.** Assert `i_load` in the cycle a base tick is due → loaded value appears, no pulse in that cycle, and the next tick comes D+1 cycles later. With the count at 10, change `i_div` from 20 to 3 → wrap and tick on the next cycle, then a tick every 4 cycles.
- **Asynchronous reset mid-second.** Pull `i_reset_n` low between clock edges → all outputs read 0 immediately, without waiting for a clock edge.
